// File: rtl/seg7_scan_reader.sv
// Loopback monitor for a multiplexed common-anode 7-segment bus: waits for each
// {dig_sel,seg} value to settle, decodes it back to BCD/blank and flags illegal patterns.
module seg7_scan_reader #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [6:0]                seg,
    input  logic [NUM_DIGITS-1:0]     dig_sel,
    output logic [4*NUM_DIGITS-1:0]   digits,
    output logic [NUM_DIGITS-1:0]     valid_mask,
    output logic                      update,
    output logic                      err,
    output logic                      frame_done
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

    logic [NUM_DIGITS-1:0]   s_sel;
    logic [6:0]              s_seg;
    logic [CW-1:0]           cnt;
    logic                    captured;
    logic [NUM_DIGITS-1:0]   seen;

    logic                    changed;
    logic                    fire;
    logic [NUM_DIGITS-1:0]   sel_low;
    logic                    no_sel;
    logic                    one_sel;
    logic [3:0]              dec_val;
    logic                    dec_ok;
    logic                    dec_blank;

    logic [CW-1:0]           cnt_d;
    logic                    captured_d;
    logic [4*NUM_DIGITS-1:0] digits_d;
    logic [NUM_DIGITS-1:0]   valid_d;
    logic [NUM_DIGITS-1:0]   seen_d;
    logic                    update_d;
    logic                    err_d;
    logic                    frame_d;

    // Capture looks at the held sample; "unchanged" means the new sample still matches it.
    always_comb begin
        changed = (dig_sel != s_sel) || (seg != s_seg);
        fire    = !changed && (cnt == CNT_MAX) && !captured;
        sel_low = ~s_sel;
        no_sel  = (sel_low == '0);
        one_sel = !no_sel && ((sel_low & (sel_low - 1'b1)) == '0);
    end

    always_comb begin
        dec_val   = 4'hF;
        dec_ok    = 1'b1;
        dec_blank = 1'b0;
        case (s_seg)
            7'b1000000: dec_val = 4'd0;
            7'b1111001: dec_val = 4'd1;
            7'b0100100: dec_val = 4'd2;
            7'b0110000: dec_val = 4'd3;
            7'b0011001: dec_val = 4'd4;
            7'b0010010: dec_val = 4'd5;
            7'b0000010: dec_val = 4'd6;
            7'b1111000: dec_val = 4'd7;
            7'b0000000: dec_val = 4'd8;
            7'b0010000: dec_val = 4'd9;
            7'b1111111: begin
                dec_ok    = 1'b0;
                dec_blank = 1'b1;
            end
            default:    dec_ok = 1'b0;
        endcase
    end

    always_comb begin
        cnt_d      = changed ? CW'(1) : ((cnt == CNT_MAX) ? cnt : cnt + 1'b1);
        captured_d = changed ? 1'b0 : (fire ? 1'b1 : captured);
        digits_d   = digits;
        valid_d    = valid_mask;
        seen_d     = seen;
        update_d   = 1'b0;
        err_d      = 1'b0;
        frame_d    = 1'b0;
        if (fire) begin
            if (one_sel) begin
                update_d = 1'b1;
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (sel_low[i]) begin
                        if (dec_ok) begin
                            digits_d[4*i +: 4] = dec_val;
                            valid_d[i]         = 1'b1;
                            seen_d[i]          = 1'b1;
                        end else if (dec_blank) begin
                            digits_d[4*i +: 4] = 4'hF;
                            valid_d[i]         = 1'b0;
                            seen_d[i]          = 1'b1;
                        end else begin
                            // Illegal pattern keeps the old value but marks it untrusted.
                            valid_d[i] = 1'b0;
                            err_d      = 1'b1;
                        end
                    end
                end
                if (&seen_d) begin
                    frame_d = 1'b1;
                    seen_d  = '0;
                end
            end else if (!no_sel) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_sel      <= '1;
            s_seg      <= '1;
            cnt        <= '0;
            captured   <= 1'b1;
            seen       <= '0;
            digits     <= '1;
            valid_mask <= '0;
            update     <= 1'b0;
            err        <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            s_sel      <= dig_sel;
            s_seg      <= seg;
            cnt        <= cnt_d;
            captured   <= captured_d;
            seen       <= seen_d;
            digits     <= digits_d;
            valid_mask <= valid_d;
            update     <= update_d;
            err        <= err_d;
            frame_done <= frame_d;
        end
    end

endmodule

// File: doc/seg7_scan_reader.md
# seg7_scan_reader

Recovers BCD digit values from a time-multiplexed, common-anode 7-segment display bus (active-low segments `{g,f,e,d,c,b,a}`, active-low digit enables). It is the inverse of the segment encoder. It samples the bus, waits for each pattern to stay stable, decodes it back to 0–9 or blank, and flags illegal patterns. It sits on the display bus as a loopback and self-check monitor for the scoreboard and display path.

## Interface
- `NUM_DIGITS`, default 4: number of multiplexed digit positions (1–8).
- `STABLE_CYCLES`, default 4: consecutive identical samples required before a capture (≥2).
- `clk` in 1: system clock. One clock domain only.
- `rst` in 1: synchronous, active-high reset.
- `seg` in 7: segment lines `{g,f,e,d,c,b,a}`, active-low. Synchronous to `clk`.
- `dig_sel` in `NUM_DIGITS`: digit anode enables, active-low. Bit i low selects position i.
- `digits` out `4*NUM_DIGITS`: decoded value of position i on `[4i+3:4i]`. Value `4'hF` means blank or unknown.
- `valid_mask` out `NUM_DIGITS`: bit i is 1 when position i holds a decoded 0–9.
- `update` out 1: one-cycle pulse on the edge after any `digits`/`valid_mask` write.
- `err` out 1: one-cycle pulse on an illegal pattern or a multi-select capture attempt.
- `frame_done` out 1: one-cycle pulse once every position has been captured since the last pulse.

## Operation
- **Input register.** `s_sel` and `s_seg` sample `dig_sel` and `seg` every edge.
- **Stability counter.** `cnt` runs 0..`STABLE_CYCLES` and saturates.
  - If the new sample differs from the held `{s_sel,s_seg}`, then `cnt` ← 1 and `captured` ← 0.
  - Otherwise `cnt` ← min(`cnt`+1, `STABLE_CYCLES`).
- **Capture condition.** A capture fires on an edge where `cnt == STABLE_CYCLES`, `captured == 0`, and the input is unchanged. That edge sets `captured` ← 1. At most one capture occurs per stable interval.
- **Capture action, chosen by `s_sel`:**
  - All ones (blanking interval): no write, no error.
  - Exactly one bit low (position i): decode `s_seg` as follows.
    - 0–9 patterns are `1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000`. Write digit i ← value, set `valid_mask[i]` ← 1, pulse `update`, set `seen[i]` ← 1.
    - `1111111`: write digit i ← `4'hF`, set `valid_mask[i]` ← 0, pulse `update`, set `seen[i]` ← 1.
    - Any other pattern: leave digit i unchanged, set `valid_mask[i]` ← 0, pulse `update` and `err`. `seen` is not set.
  - More than one bit low: no write, pulse `err`.
- **Frame tracking.**
  - When a capture makes `seen` all ones, pulse `frame_done` and clear `seen` to 0 on that same edge.
  - A capture that re-hits an already-seen position leaves `seen` unchanged.
- **Reset values.**
  - `digits` = all `4'hF`.
  - `valid_mask`, `update`, `err`, `frame_done`, `seen`, `cnt` = 0.
  - `captured` = 1.
  - `s_sel` and `s_seg` = all ones.
- **Reset mid-capture.** Any pending stability count is discarded. A bus value held across reset release needs a full `STABLE_CYCLES` again before capture.

## Timing
- Let E0 be the first edge that samples a new bus value, with the bus held constant afterward. Then:
  - `cnt` reaches `STABLE_CYCLES` after edge E0+`STABLE_CYCLES`−1.
  - The capture happens at edge E0+`STABLE_CYCLES`.
  - `update`, `err`, and `frame_done` are registered. They are high for exactly the cycle after that edge.
- Any bus change before the capture edge restarts the count. Glitches shorter than `STABLE_CYCLES` edges never capture.
- **Back-to-back intervals.** The next capture can occur no earlier than `STABLE_CYCLES` edges after the previous one.
- **Simultaneous events.**
  - `update` and `err` may pulse together (illegal pattern).
  - `update` and `frame_done` pulse together on the completing capture.
- All outputs are registered. There are no combinational paths from input to output.

## Test plan
- **Reset and idle.** Assert `rst` for 2 cycles with the bus all ones → `digits` = `16'hFFFF`, `valid_mask` = 0, no pulses for 20 cycles.
- **Single digit, STABLE_CYCLES=4.** Drive `dig_sel`=`1110`, `seg`=`0100100` before edge E0 → exactly one `update` high after edge E0+4. `digits[3:0]` = 2, `valid_mask` = `0001`. No further pulses while the bus is held.
- **Full scan.** Cycle positions 0–3 showing 1, 2, 3, 4, 6 cycles each → `digits` = `16'h4321`, `valid_mask` = `1111`. `frame_done` pulses once, coincident with the position-3 `update`.
- **Glitch rejection.** Hold `1110`/`1111001` for 3 cycles, then switch to `1101`/`0010010` and hold → no capture for position 0. Position 1 ← 5 at 4 edges after the switch.
- **Illegal pattern and blank.** Drive `1011`/`0101010` → `err` and `update` pulse, digit 2 unchanged, `valid_mask[2]` = 0. Then `1011`/`1111111` → digit 2 = F, no `err`.
- **Multi-select and mid-count reset.** Drive `dig_sel`=`1100` → `err` only, no `digits` change. Next, hold a valid pattern for 2 cycles, assert `rst` for 1 cycle, and keep the pattern held → capture occurs 4 edges after the first edge following reset release.
